// File: rtl/vc_arbiter_ctrl_pkg.sv
// rtl/vc_arbiter_ctrl_pkg.sv - shared state encodings and word-layout helpers for the VC arbiter
package vc_arbiter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } vc_state_t;

    localparam int DATA_SIZE_DEF = 10;

    // The destination bit sits just below the word's top bit.
    function automatic int dest_bit(input int data_size);
        return data_size - 2;
    endfunction

endpackage

// File: rtl/vc_rr_grant.sv
// rtl/vc_rr_grant.sv - VC0-priority grant with a burst limit that protects VC1 from starvation
module vc_rr_grant
#(
    parameter int MAX_BURST = 4
)
(
    input  logic clk,
    input  logic reset_L,
    input  logic enable,
    input  logic empty_vc0,
    input  logic empty_vc1,
    output logic grant_vc0,
    output logic grant_vc1
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

    logic [CNT_W-1:0] burst_cnt;

    // Pick at most one source; VC1 wins only once VC0 has used up its burst allowance.
    always_comb begin
        grant_vc0 = 1'b0;
        grant_vc1 = 1'b0;
        if (enable) begin
            if ((burst_cnt >= BURST_LIM) && !empty_vc1) begin
                grant_vc1 = 1'b1;
            end else if (!empty_vc0) begin
                grant_vc0 = 1'b1;
            end else if (!empty_vc1) begin
                grant_vc1 = 1'b1;
            end
        end
    end

    // Count consecutive VC0 grants only while VC1 is actually waiting.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            burst_cnt <= '0;
        end else if (empty_vc1 || grant_vc1) begin
            burst_cnt <= '0;
        end else if (grant_vc0) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vc_arbiter_ctrl.sv
// rtl/vc_arbiter_ctrl.sv - VC FIFO arbiter, destination router, threshold programming and sequencing FSM
module vc_arbiter_ctrl
    import vc_arbiter_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int MAX_BURST = 4,
    parameter int TH_W      = 3
)
(
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 init,
    input  logic [TH_W-1:0]      umbral_af,
    input  logic [TH_W-1:0]      umbral_ae,
    input  logic                 fifo_empty_vc0,
    input  logic                 fifo_empty_vc1,
    input  logic [DATA_SIZE-1:0] data_vc0,
    input  logic [DATA_SIZE-1:0] data_vc1,
    input  logic                 pause_d0,
    input  logic                 pause_d1,
    output logic [TH_W-1:0]      afVC_o,
    output logic [TH_W-1:0]      aeVC_o,
    output logic                 pop_vc0,
    output logic                 pop_vc1,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 push_d0,
    output logic                 push_d1,
    output logic                 idle_o,
    output logic [1:0]           state_o
);

    localparam int DEST_BIT = dest_bit(DATA_SIZE);

    vc_state_t            state, state_n;
    logic                 grant_en;
    logic                 infl_valid;
    logic                 infl_src;
    logic [DATA_SIZE-1:0] infl_word;

    assign state_o   = state;
    // A pause on either destination blocks all pops: the word's destination is unknown until read.
    // Popping is also held off while init is requested or reset is asserted, so no word is lost.
    assign grant_en  = reset_L && (state == ST_ACTIVE) && !init && !pause_d0 && !pause_d1;
    assign infl_word = infl_src ? data_vc1 : data_vc0;

    vc_rr_grant #(
        .MAX_BURST (MAX_BURST)
    ) u_grant (
        .clk       (clk),
        .reset_L   (reset_L),
        .enable    (grant_en),
        .empty_vc0 (fifo_empty_vc0),
        .empty_vc1 (fifo_empty_vc1),
        .grant_vc0 (pop_vc0),
        .grant_vc1 (pop_vc1)
    );

    // Sequencing FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state <= ST_RESET;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode; init request always pulls the controller back to INIT.
    always_comb begin
        state_n = state;
        case (state)
            ST_RESET:  state_n = ST_INIT;
            ST_INIT:   if (!init) state_n = ST_IDLE;
            ST_IDLE: begin
                if (init) begin
                    state_n = ST_INIT;
                end else if (!fifo_empty_vc0 || !fifo_empty_vc1) begin
                    state_n = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (init) begin
                    state_n = ST_INIT;
                end else if (fifo_empty_vc0 && fifo_empty_vc1) begin
                    state_n = ST_IDLE;
                end
            end
            default:   state_n = ST_RESET;
        endcase
    end

    // Thresholds track the config inputs only while INIT is being held.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            afVC_o <= '0;
            aeVC_o <= '0;
        end else if ((state == ST_INIT) && init) begin
            afVC_o <= umbral_af;
            aeVC_o <= umbral_ae;
        end
    end

    // Pop -> in-flight -> registered push; an in-flight word always completes unless reset hits.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            infl_valid <= 1'b0;
            infl_src   <= 1'b0;
            data_out   <= '0;
            push_d0    <= 1'b0;
            push_d1    <= 1'b0;
            idle_o     <= 1'b0;
        end else begin
            infl_valid <= pop_vc0 || pop_vc1;
            infl_src   <= pop_vc1;
            push_d0    <= 1'b0;
            push_d1    <= 1'b0;
            if (infl_valid) begin
                data_out <= infl_word;
                push_d0  <= !infl_word[DEST_BIT];
                push_d1  <= infl_word[DEST_BIT];
            end
            idle_o <= (state_n == ST_IDLE) && !(pop_vc0 || pop_vc1);
        end
    end

endmodule

// File: tb/tb_vc_arbiter_ctrl.sv
// tb/tb_vc_arbiter_ctrl.sv - randomized self-checking bench for vc_arbiter_ctrl against a queue-based reference
module tb_vc_arbiter_ctrl;

    localparam int DS = 10;
    localparam int MB = 4;
    localparam int TW = 3;

    logic          clk;
    logic          reset_L;
    logic          init;
    logic [TW-1:0] umbral_af;
    logic [TW-1:0] umbral_ae;
    logic          fifo_empty_vc0;
    logic          fifo_empty_vc1;
    logic [DS-1:0] data_vc0;
    logic [DS-1:0] data_vc1;
    logic          pause_d0;
    logic          pause_d1;
    logic [TW-1:0] afVC_o;
    logic [TW-1:0] aeVC_o;
    logic          pop_vc0;
    logic          pop_vc1;
    logic [DS-1:0] data_out;
    logic          push_d0;
    logic          push_d1;
    logic          idle_o;
    logic [1:0]    state_o;

    vc_arbiter_ctrl #(
        .DATA_SIZE (DS),
        .MAX_BURST (MB),
        .TH_W      (TW)
    ) dut (
        .clk            (clk),
        .reset_L        (reset_L),
        .init           (init),
        .umbral_af      (umbral_af),
        .umbral_ae      (umbral_ae),
        .fifo_empty_vc0 (fifo_empty_vc0),
        .fifo_empty_vc1 (fifo_empty_vc1),
        .data_vc0       (data_vc0),
        .data_vc1       (data_vc1),
        .pause_d0       (pause_d0),
        .pause_d1       (pause_d1),
        .afVC_o         (afVC_o),
        .aeVC_o         (aeVC_o),
        .pop_vc0        (pop_vc0),
        .pop_vc1        (pop_vc1),
        .data_out       (data_out),
        .push_d0        (push_d0),
        .push_d1        (push_d1),
        .idle_o         (idle_o),
        .state_o        (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DS-1:0] q0[$];
    logic [DS-1:0] q1[$];

    int            m_state;
    logic [TW-1:0] m_af;
    logic [TW-1:0] m_ae;
    logic [DS-1:0] m_dout;
    logic          m_p0;
    logic          m_p1;
    logic          m_idle;
    int            m_streak;
    logic          m_if_v;
    logic [DS-1:0] m_if_word;

    int checks;
    int failures;
    logic rec_order;
    int order[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic refresh_empty();
        fifo_empty_vc0 = (q0.size() == 0);
        fifo_empty_vc1 = (q1.size() == 0);
    endtask

    task automatic load(input int vc, input logic [DS-1:0] w);
        if (vc == 0) q0.push_back(w);
        else         q1.push_back(w);
        refresh_empty();
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_af     = '0;
        m_ae     = '0;
        m_dout   = '0;
        m_p0     = 1'b0;
        m_p1     = 1'b0;
        m_idle   = 1'b0;
        m_streak = 0;
        m_if_v   = 1'b0;
        m_if_word = '0;
    endtask

    task automatic step(input logic rst_n, input logic ini, input logic p0, input logic p1,
                        input logic [TW-1:0] af, input logic [TW-1:0] ae);
        logic          e_g0, e_g1, obs0, obs1;
        int            n_state;
        logic          has0, has1;
        logic [DS-1:0] w;
        @(negedge clk);
        reset_L   = rst_n;
        init      = ini;
        pause_d0  = p0;
        pause_d1  = p1;
        umbral_af = af;
        umbral_ae = ae;
        #1;
        check_val("state", state_o, m_state);
        check_val("af", afVC_o, m_af);
        check_val("ae", aeVC_o, m_ae);
        check_val("data_out", data_out, m_dout);
        check_val("push_d0", push_d0, m_p0);
        check_val("push_d1", push_d1, m_p1);
        check_val("idle", idle_o, m_idle);

        has0 = (q0.size() > 0);
        has1 = (q1.size() > 0);
        e_g0 = 1'b0;
        e_g1 = 1'b0;
        if (rst_n && m_state == 3 && !ini && !p0 && !p1) begin
            if (m_streak >= MB && has1) e_g1 = 1'b1;
            else if (has0)              e_g0 = 1'b1;
            else if (has1)              e_g1 = 1'b1;
        end
        obs0 = pop_vc0;
        obs1 = pop_vc1;
        check_val("pop_vc0", obs0, e_g0);
        check_val("pop_vc1", obs1, e_g1);
        if (rec_order) begin
            if (obs0) order.push_back(0);
            if (obs1) order.push_back(1);
        end

        case (m_state)
            0:       n_state = 1;
            1:       n_state = ini ? 1 : 2;
            2:       n_state = ini ? 1 : ((has0 || has1) ? 3 : 2);
            default: n_state = ini ? 1 : ((!has0 && !has1) ? 2 : 3);
        endcase

        @(posedge clk);
        #1;
        if (obs0 && q0.size() > 0) begin
            w = q0.pop_front();
            data_vc0 = w;
        end
        if (obs1 && q1.size() > 0) begin
            w = q1.pop_front();
            data_vc1 = w;
        end
        refresh_empty();

        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_state == 1 && ini) begin
                m_af = af;
                m_ae = ae;
            end
            if (!has1 || e_g1) m_streak = 0;
            else if (e_g0)     m_streak = m_streak + 1;
            m_p0 = 1'b0;
            m_p1 = 1'b0;
            if (m_if_v) begin
                m_dout = m_if_word;
                m_p0   = !m_if_word[DS-2];
                m_p1   = m_if_word[DS-2];
            end
            m_if_v = e_g0 || e_g1;
            if (e_g0 || e_g1) m_if_word = w;
            m_idle  = (n_state == 2) && !(e_g0 || e_g1);
            m_state = n_state;
        end
    endtask

    initial begin
        int exp_order[8];
        checks    = 0;
        failures  = 0;
        rec_order = 1'b0;
        reset_L   = 1'b0;
        init      = 1'b0;
        umbral_af = '0;
        umbral_ae = '0;
        pause_d0  = 1'b0;
        pause_d1  = 1'b0;
        data_vc0  = '0;
        data_vc1  = '0;
        refresh_empty();
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // reset, then INIT with af=3 ae=1
        step(0, 1, 0, 0, 3'd3, 3'd1);
        step(0, 1, 0, 0, 3'd3, 3'd1);
        repeat (3) step(1, 1, 0, 0, 3'd3, 3'd1);

        // two VC0 words routed by destination bit
        load(0, 10'h100);
        load(0, 10'h005);
        repeat (6) step(1, 0, 0, 0, 3'd0, 3'd0);

        // burst limit ordering
        for (int i = 0; i < 6; i++) load(0, DS'($urandom));
        for (int i = 0; i < 2; i++) load(1, DS'($urandom));
        rec_order = 1'b1;
        repeat (14) step(1, 0, 0, 0, 3'd0, 3'd0);
        rec_order = 1'b0;
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 1};
        check_val("t3_grant_count", order.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < order.size()) check_val("t3_grant_order", order[i], exp_order[i]);
        end

        // pause gating
        for (int i = 0; i < 4; i++) load(0, DS'($urandom));
        repeat (2) step(1, 0, 0, 0, 3'd0, 3'd0);
        repeat (3) step(1, 0, 1, 0, 3'd0, 3'd0);
        repeat (6) step(1, 0, 0, 0, 3'd0, 3'd0);

        // init while a word is in flight
        for (int i = 0; i < 3; i++) load(0, DS'($urandom));
        repeat (2) step(1, 0, 0, 0, 3'd0, 3'd0);
        repeat (2) step(1, 1, 0, 0, 3'd5, 3'd6);
        repeat (6) step(1, 0, 0, 0, 3'd0, 3'd0);

        // reset the cycle after a pop
        for (int i = 0; i < 3; i++) load(0, DS'($urandom));
        repeat (2) step(1, 0, 0, 0, 3'd0, 3'd0);
        step(0, 0, 0, 0, 3'd0, 3'd0);
        step(1, 1, 0, 0, 3'd2, 3'd4);
        repeat (8) step(1, 0, 0, 0, 3'd0, 3'd0);

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            if (q0.size() < 8 && $urandom_range(0, 2) == 0) load(0, DS'($urandom));
            if (q1.size() < 8 && $urandom_range(0, 3) == 0) load(1, DS'($urandom));
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0),
                 TW'($urandom), TW'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
